// File: rtl/md_issue_if.sv
// Signal bundle between the pipeline/mul-div unit side and md_issue_ctrl.
// master: the pipeline stages and the mul/div unit; slave: the issue controller.
interface md_issue_if;
  logic        d_valid;
  logic [3:0]  d_md_op;
  logic        e_valid;
  logic        e_flush;
  logic [3:0]  e_md_op;
  logic [31:0] e_srca;
  logic [31:0] e_srcb;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic [31:0] md_srca;
  logic [31:0] md_srcb;
  logic [2:0]  md_ctrl;
  logic        md_used;
  logic        stall_d;
  logic [31:0] mf_data;
  logic        mf_valid;
  logic        md_err;

  modport master (
    output d_valid, d_md_op, e_valid, e_flush, e_md_op, e_srca, e_srcb,
           md_busy, md_hi, md_lo,
    input  md_srca, md_srcb, md_ctrl, md_used, stall_d, mf_data, mf_valid, md_err
  );

  modport slave (
    input  d_valid, d_md_op, e_valid, e_flush, e_md_op, e_srca, e_srcb,
           md_busy, md_hi, md_lo,
    output md_srca, md_srcb, md_ctrl, md_used, stall_d, mf_data, mf_valid, md_err
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Mul/div issue controller: launches E-stage mul/div/move-to ops into the
// unit, holds the D stage while the unit is occupied, captures MFHI/MFLO
// results and flags a unit that stays busy too long (sticky md_err).
module md_issue_ctrl (
  input  logic       clk,
  input  logic       reset,
  md_issue_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       e_live;
  logic       e_start;
  logic       e_mf;
  logic       d_md;

  // Decode which E-stage request is accepted this cycle (only from IDLE, never when flushed)
  always_comb begin
    e_live  = bus.e_valid && !bus.e_flush && (state == IDLE);
    e_start = e_live && (bus.e_md_op >= 4'd1) && (bus.e_md_op <= 4'd6);
    e_mf    = e_live && ((bus.e_md_op == 4'd7) || (bus.e_md_op == 4'd8));
    d_md    = bus.d_valid && (bus.d_md_op >= 4'd1) && (bus.d_md_op <= 4'd8);
  end

  assign bus.stall_d = d_md && ((state != IDLE) || e_start);

  // Issue FSM, operand/control registers, watchdog counter and MF capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      bus.md_used <= 1'b0;
      bus.md_ctrl <= 3'd0;
      bus.md_srca <= 32'd0;
      bus.md_srcb <= 32'd0;
      bus.mf_data <= 32'd0;
      bus.mf_valid <= 1'b0;
      bus.md_err  <= 1'b0;
    end else begin
      bus.md_used  <= 1'b0;
      bus.mf_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (e_start) begin
            bus.md_srca <= bus.e_srca;
            bus.md_srcb <= bus.e_srcb;
            bus.md_ctrl <= bus.e_md_op[2:0];
            bus.md_used <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.md_ctrl <= 3'd4) begin
            wait_cnt <= 4'd0;
            state    <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd15) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
          // the counter reaches 12 on this edge: the unit is considered hung
          if (wait_cnt == 4'd11) begin
            bus.md_err <= 1'b1;
          end
          // busy cannot be seen yet in the first WAIT cycle, so ignore it there
          if ((wait_cnt != 4'd0) && !bus.md_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (e_mf) begin
        bus.mf_valid <= 1'b1;
        bus.mf_data  <= (bus.e_md_op == 4'd7) ? bus.md_hi : bus.md_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: a stub mul/div unit, a
// transaction-level reference model compared every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_md_issue_ctrl;

  logic clk;
  logic reset;
  md_issue_if bus ();

  md_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  bit cmp_en     = 0;
  logic seen_stall;

  // Stub unit configuration and state
  int          stub_len = 5;
  int          stub_lag = 0;
  int          busy_left = 0;
  int          lag_left  = 0;
  logic [31:0] hi_q = 32'd0;
  logic [31:0] lo_q = 32'd0;

  assign bus.md_busy = (lag_left == 0) && (busy_left > 0);
  assign bus.md_hi   = hi_q;
  assign bus.md_lo   = lo_q;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // One pipeline cycle: drive inputs, sample stall_d mid-cycle, return just after the edge
  task automatic applyStimulus(input logic dv, input logic [3:0] dop, input logic ev,
                               input logic ef, input logic [3:0] eop,
                               input logic [31:0] a, input logic [31:0] b);
    bus.d_valid = dv;
    bus.d_md_op = dop;
    bus.e_valid = ev;
    bus.e_flush = ef;
    bus.e_md_op = eop;
    bus.e_srca  = a;
    bus.e_srcb  = b;
    @(negedge clk);
    seen_stall = bus.stall_d;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Stub mul/div unit: computes HI/LO on the start strobe and stays busy stub_len cycles after stub_lag cycles
  always @(posedge clk) begin
    longint sa, sb;
    logic [63:0] p;
    if (reset) begin
      busy_left <= 0;
      lag_left  <= 0;
    end else if (bus.md_used) begin
      sa = longint'($signed(bus.md_srca));
      sb = longint'($signed(bus.md_srcb));
      case (bus.md_ctrl)
        3'd1: begin p = 64'(sa * sb); hi_q <= p[63:32]; lo_q <= p[31:0]; end
        3'd2: begin p = {32'd0, bus.md_srca} * {32'd0, bus.md_srcb}; hi_q <= p[63:32]; lo_q <= p[31:0]; end
        3'd3: begin lo_q <= 32'(sa / sb); hi_q <= 32'(sa % sb); end
        3'd4: begin lo_q <= bus.md_srca / bus.md_srcb; hi_q <= bus.md_srca % bus.md_srcb; end
        3'd5: hi_q <= bus.md_srca;
        3'd6: lo_q <= bus.md_srca;
        default: ;
      endcase
      if (bus.md_ctrl >= 3'd1 && bus.md_ctrl <= 3'd4) begin
        lag_left  <= stub_lag;
        busy_left <= stub_len;
      end
    end else if (lag_left > 0) begin
      lag_left <= lag_left - 1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
  end

  // Reference model state: one op in flight at most, tracked by phase and elapsed wait cycles
  bit          m_inflight = 0;
  bit          m_issue_ph = 0;
  int          m_op       = 0;
  int          m_waits    = 0;
  bit          m_used     = 0;
  logic [2:0]  m_ctrl     = 3'd0;
  logic [31:0] m_srca     = 32'd0;
  logic [31:0] m_srcb     = 32'd0;
  bit          m_mfv      = 0;
  logic [31:0] m_mfd      = 32'd0;
  bit          m_err      = 0;

  function automatic bit accepted_unit_op();
    return bus.e_valid && !bus.e_flush && !m_inflight && bus.e_md_op inside {[4'd1:4'd6]};
  endfunction

  // Reference model advance at each edge
  always @(posedge clk) begin
    bit go, mf;
    if (reset) begin
      m_inflight = 0; m_issue_ph = 0; m_waits = 0; m_op = 0;
      m_used = 0; m_ctrl = 3'd0; m_srca = 32'd0; m_srcb = 32'd0;
      m_mfv = 0; m_mfd = 32'd0; m_err = 0;
    end else begin
      go = accepted_unit_op();
      mf = bus.e_valid && !bus.e_flush && !m_inflight && (bus.e_md_op == 4'd7 || bus.e_md_op == 4'd8);
      if (m_inflight) begin
        if (m_issue_ph) begin
          m_issue_ph = 0;
          m_waits    = 0;
          if (m_op >= 5) m_inflight = 0;
        end else begin
          if (m_waits >= 1 && !bus.md_busy) m_inflight = 0;
          m_waits++;
          if (m_waits == 12) m_err = 1;
        end
      end
      m_used = go;
      if (go) begin
        m_inflight = 1;
        m_issue_ph = 1;
        m_op       = int'(bus.e_md_op);
        m_ctrl     = bus.e_md_op[2:0];
        m_srca     = bus.e_srca;
        m_srcb     = bus.e_srcb;
      end
      m_mfv = mf;
      if (mf) m_mfd = (bus.e_md_op == 4'd7) ? bus.md_hi : bus.md_lo;
    end
  end

  // Compare every DUT output against the model mid-cycle
  always @(negedge clk) begin
    bit exp_stall;
    if (cmp_en) begin
      exp_stall = bus.d_valid && (bus.d_md_op inside {[4'd1:4'd8]}) && (m_inflight || accepted_unit_op());
      checkOutput("stall_d",  32'(bus.stall_d),  32'(exp_stall));
      checkOutput("md_used",  32'(bus.md_used),  32'(m_used));
      checkOutput("md_ctrl",  32'(bus.md_ctrl),  32'(m_ctrl));
      checkOutput("md_srca",  bus.md_srca,       m_srca);
      checkOutput("md_srcb",  bus.md_srcb,       m_srcb);
      checkOutput("mf_valid", 32'(bus.mf_valid), 32'(m_mfv));
      checkOutput("mf_data",  bus.mf_data,       m_mfd);
      checkOutput("md_err",   32'(bus.md_err),   32'(m_err));
    end
  end

  // Directed scenarios
  initial begin
    int stalls;
    reset = 1'b1;
    bus.d_valid = 1'b0; bus.d_md_op = 4'd0; bus.e_valid = 1'b0; bus.e_flush = 1'b0;
    bus.e_md_op = 4'd0; bus.e_srca = 32'd0; bus.e_srcb = 32'd0;
    @(posedge clk);
    #1;
    cmp_en = 1;
    bubble();
    reset = 1'b0;
    checkOutput("reset_md_used", 32'(bus.md_used), 32'd0);
    checkOutput("reset_md_ctrl", 32'(bus.md_ctrl), 32'd0);
    checkOutput("reset_md_err",  32'(bus.md_err),  32'd0);
    checkOutput("reset_mf_data", bus.mf_data,      32'd0);

    // MULT with MFLO waiting in D
    $display("[TB] MULT test");
    stub_len = 5; stub_lag = 0;
    applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 4'd1, 32'hFFFFFFFE, 32'd3);
    stalls = int'(seen_stall);
    checkOutput("mult_md_used", 32'(bus.md_used), 32'd1);
    checkOutput("mult_md_ctrl", 32'(bus.md_ctrl), 32'd1);
    for (int i = 0; i < 40 && seen_stall; i++) begin
      applyStimulus(1'b1, 4'd8, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      stalls += int'(seen_stall);
    end
    checkOutput("mult_stall_cycles", 32'(stalls), 32'd8);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 32'd0, 32'd0);
    checkOutput("mult_mf_valid", 32'(bus.mf_valid), 32'd1);
    checkOutput("mult_mf_data",  bus.mf_data,       32'hFFFFFFFA);
    bubble();
    checkOutput("mult_mf_pulse", 32'(bus.mf_valid), 32'd0);

    // MTHI then MFHI
    $display("[TB] MTHI test");
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 4'd5, 32'h12345678, 32'hDEADBEEF);
    stalls = int'(seen_stall);
    for (int i = 0; i < 40 && seen_stall; i++) begin
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      stalls += int'(seen_stall);
    end
    checkOutput("mthi_stall_cycles", 32'(stalls), 32'd2);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 32'd0, 32'd0);
    checkOutput("mthi_mf_data", bus.mf_data, 32'h12345678);

    // Flush and illegal op classes
    $display("[TB] flush test");
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 4'd3, 32'd50, 32'd5);
    checkOutput("flush_stall", 32'(seen_stall), 32'd0);
    checkOutput("flush_md_used", 32'(bus.md_used), 32'd0);
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 4'd11, 32'd1, 32'd1);
    checkOutput("op11_stall", 32'(seen_stall), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 4'd7, 32'd0, 32'd0);
    checkOutput("flush_mf_valid", 32'(bus.mf_valid), 32'd0);
    applyStimulus(1'b0, 4'd4, 1'b1, 1'b0, 4'd6, 32'hA5A5A5A5, 32'd0);
    checkOutput("dvalid0_stall", 32'(seen_stall), 32'd0);
    bubble();
    bubble();

    // DIVU in E, MULTU in D, unit busy appears one cycle late
    $display("[TB] back-to-back test");
    stub_len = 8; stub_lag = 1;
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 4'd4, 32'd100, 32'd7);
    stalls = int'(seen_stall);
    for (int i = 0; i < 40 && seen_stall; i++) begin
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      stalls += int'(seen_stall);
    end
    checkOutput("b2b_stall_cycles", 32'(stalls), 32'd12);
    checkOutput("b2b_md_err", 32'(bus.md_err), 32'd0);
    stub_len = 5; stub_lag = 0;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 32'h80000000, 32'd4);
    checkOutput("b2b_multu_used", 32'(bus.md_used), 32'd1);
    checkOutput("b2b_multu_ctrl", 32'(bus.md_ctrl), 32'd2);
    repeat (10) bubble();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 32'd0, 32'd0);
    checkOutput("b2b_multu_hi", bus.mf_data, 32'd2);

    // Watchdog: unit hangs for 20 cycles
    $display("[TB] watchdog test");
    stub_len = 20; stub_lag = 0;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 32'd100, 32'd7);
    bubble();
    repeat (11) bubble();
    checkOutput("wd_err_before", 32'(bus.md_err), 32'd0);
    bubble();
    checkOutput("wd_err_set", 32'(bus.md_err), 32'd1);
    repeat (12) bubble();
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("wd_exit_stall", 32'(seen_stall), 32'd0);
    checkOutput("wd_err_sticky", 32'(bus.md_err), 32'd1);
    reset = 1'b1;
    bubble();
    reset = 1'b0;
    checkOutput("wd_err_cleared", 32'(bus.md_err), 32'd0);

    // Reset during the third WAIT cycle of a MULT
    $display("[TB] reset test");
    stub_len = 5; stub_lag = 0;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 32'h00001234, 32'h00005678);
    repeat (3) bubble();
    reset = 1'b1;
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    reset = 1'b0;
    checkOutput("rst_md_used", 32'(bus.md_used), 32'd0);
    checkOutput("rst_md_ctrl", 32'(bus.md_ctrl), 32'd0);
    checkOutput("rst_md_srca", bus.md_srca,      32'd0);
    checkOutput("rst_mf_data", bus.mf_data,      32'd0);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("rst_stall_drop", 32'(seen_stall), 32'd0);
    checkOutput("rst_no_reissue", 32'(bus.md_used), 32'd0);
    repeat (3) bubble();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 The block SHALL have these ports: clk (input, 1, clock); reset (input, 1, synchronous, active-high).
REQ-002 The block SHALL have these decode-stage ports: d_valid (input, 1, D-stage instruction valid); d_md_op (input, 4, D-stage mul/div op class).
REQ-003 The block SHALL have these execute-stage ports: e_valid (input, 1, E-stage instruction valid); e_flush (input, 1, kill E-stage instruction); e_md_op (input, 4, E-stage op class); e_srca and e_srcb (input, 32 each, E-stage operands).
REQ-004 The block SHALL have these unit-return ports: md_busy (input, 1, mul/div unit busy); md_hi and md_lo (input, 32 each, unit HI/LO).
REQ-005 The block SHALL have these unit-drive ports: md_srca and md_srcb (output, 32 each, operands to unit); md_ctrl (output, 3, unit control); md_used (output, 1, unit start strobe).
REQ-006 The block SHALL have these result and status ports: stall_d (output, 1, hold D stage); mf_data (output, 32, MFHI/MFLO result); mf_valid (output, 1, mf_data valid pulse); md_err (output, 1, sticky watchdog error).
REQ-007 Op class encoding SHALL be: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, and 9-15 treated as 0.
REQ-008 Unit control encoding SHALL equal the op class for classes 1-6; md_ctrl SHALL be 0 when no op is issued.

Function
REQ-009 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-010 In a given cycle, e_start SHALL be true when e_valid=1, e_flush=0, e_md_op is in 1..6, and the state is IDLE.
REQ-011 On e_start, at the next edge the block SHALL register md_srca=e_srca, md_srcb=e_srcb and md_ctrl=e_md_op, set md_used=1, and enter ISSUE.
REQ-012 md_used SHALL be high for exactly one cycle (the ISSUE cycle); md_srca, md_srcb and md_ctrl SHALL hold their values until the next e_start.
REQ-013 From ISSUE, ctrl 1-4 SHALL go to WAIT and ctrl 5-6 SHALL return to IDLE.
REQ-014 In WAIT, the block SHALL return to IDLE on the first cycle with md_busy=0, except in the first WAIT cycle: busy is only visible one edge after md_used, so a low md_busy there SHALL be ignored.
REQ-015 The WAIT counter SHALL reset to 0 on WAIT entry, increment each WAIT cycle, and saturate at 15.
REQ-016 md_err SHALL set when the WAIT counter reaches 12 (unit hung) and SHALL hold until reset; the FSM SHALL still exit WAIT when md_busy falls.
REQ-017 stall_d SHALL be combinational: stall_d = d_valid AND d_md_op in 1..8 AND (state != IDLE OR e_start).
REQ-018 stall_d SHALL never assert for d_md_op=0 or d_valid=0.
REQ-019 When e_valid=1, e_flush=0, e_md_op is 7 or 8, and the state is IDLE, the next edge SHALL register mf_data (md_hi for 7, md_lo for 8) and pulse mf_valid=1 for one cycle.
REQ-020 mf_valid SHALL be 0 in all other cycles, and mf_data SHALL hold its last value.
REQ-021 An MFHI/MFLO in E while the state is not IDLE SHALL produce no mf_valid; stall_d guarantees this cannot occur in a legal pipeline.
REQ-022 e_flush=1 SHALL suppress e_start and mf capture in that cycle; it SHALL NOT abort an op already in ISSUE or WAIT.
REQ-023 Multiply/divide arithmetic, signedness and latency SHALL be owned by the unit; this block SHALL not interpret operands.

Reset
REQ-024 On reset, the block SHALL enter IDLE and clear these registers: md_used=0, md_ctrl=0, md_srca=0, md_srcb=0, mf_data=0, mf_valid=0, md_err=0, WAIT counter=0.
REQ-025 Reset mid-ISSUE or mid-WAIT SHALL abandon the op with no md_used re-issue; stall_d SHALL drop in the first cycle after reset unless e_start holds.

Verification
REQ-026 MULT test: E op 1, e_srca=0xFFFFFFFE, e_srcb=3 -> next cycle md_used=1, md_ctrl=1; the unit drives busy for 5 cycles; a D-stage MFLO sees stall_d=1 until IDLE; then mf_data=0xFFFFFFFA and mf_valid pulses once.
REQ-027 MTHI test: E op 5, e_srca=0x12345678 -> one ISSUE cycle, then IDLE with no WAIT; a following MFHI yields mf_data=0x12345678 one cycle after reaching E.
REQ-028 Flush test: E op 3 with e_flush=1 -> md_used stays 0, state stays IDLE, stall_d=0 for D op 0.
REQ-029 Back-to-back test: DIVU in E and MULTU in D -> stall_d=1 from the e_start cycle through ISSUE and WAIT (>=11 cycles); the MULTU issues only after IDLE.
REQ-030 Watchdog test: a stubbed unit holds md_busy=1 for 20 cycles after a DIV -> md_err=1 on the 12th WAIT cycle and stays high after busy falls; only reset clears it.
REQ-031 Reset test: reset asserted in the 3rd WAIT cycle of a MULT -> next cycle IDLE with all outputs at reset values and md_used=0.
